// File: rtl/adc_spi_pkg.sv
// Frame layout and FSM encodings shared by the ADC responder and the SPI master.
package adc_spi_pkg;

    localparam int unsigned DATA_W      = 12;
    localparam int unsigned LEAD_ZEROS  = 4;
    localparam int unsigned FRAME_LEN   = LEAD_ZEROS + DATA_W;
    localparam int unsigned CH_NUM      = 8;
    localparam int unsigned CH_W        = 3;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CNT_W       = 5;
    localparam int unsigned ADDR_FIRST  = 3;
    localparam int unsigned ADDR_LAST   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [LEAD_ZEROS-1:0] lead;
        logic [DATA_W-1:0]     sample;
    } frame_t;

    // Builds the on-wire frame word: leading zeros then the sample, MSB first.
    function automatic logic [FRAME_LEN-1:0] frame_word(input logic [DATA_W-1:0] sample);
        frame_t f;
        f.lead   = '0;
        f.sample = sample;
        return f;
    endfunction

endpackage

// File: rtl/adc_spi_responder_if.sv
// SPI pin bundle between the demodulator master and the ADC responder.
interface adc_spi_responder_if;

    logic cs;
    logic sclk;
    logic din;
    logic dout;

    modport master (output cs, output sclk, output din, input dout);
    modport slave  (input cs, input sclk, input din, output dout);

endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin plus registered edge flags.
module spi_pin_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;

    // Synchronizer chain; level is the previous synchronized value so rise/fall align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            level  <= RESET_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin};
            level  <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~level;
            fall   <= ~sync_q[STAGES-1] & level;
        end
    end

endmodule

// File: rtl/adc_spi_responder.sv
// SPI-slave stand-in for the 8-channel 12-bit serial ADC, oversampled in the clk domain.
module adc_spi_responder
    import adc_spi_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    adc_spi_responder_if.slave        spi,
    input  logic [CH_NUM*DATA_W-1:0]  ch_data,
    output logic [CH_W-1:0]           cur_ch,
    output logic                      frame_done,
    output logic                      frame_err
);

    localparam int unsigned SETTLE   = SYNC_STAGES + 1;
    localparam int unsigned SETTLE_W = $clog2(SETTLE + 1);

    logic cs_level, cs_rise, cs_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic din_level, din_rise, din_fall;
    logic unused_pin_flags;

    state_t                 state, state_nxt;
    logic [FRAME_LEN-1:0]   shreg, shreg_nxt;
    logic [CNT_W-1:0]       fcnt, fcnt_nxt;
    logic [CNT_W-1:0]       rcnt, rcnt_nxt, rcnt_inc;
    logic [CH_W-1:0]        addr_sh, addr_nxt;
    logic [CH_W-1:0]        cur_ch_nxt;
    logic                   dout_q, dout_nxt;
    logic                   done_nxt, err_nxt;
    logic [DATA_W-1:0]      sample_c;
    logic [SETTLE_W-1:0]    settle_cnt;
    logic                   armed;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .pin(spi.cs),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
        .clk(clk), .rst(rst), .pin(spi.sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_din_sync (
        .clk(clk), .rst(rst), .pin(spi.din),
        .level(din_level), .rise(din_rise), .fall(din_fall)
    );

    assign unused_pin_flags = sclk_level ^ din_rise ^ din_fall;

    assign sample_c = ch_data[32'(cur_ch) * DATA_W +: DATA_W];
    assign spi.dout = dout_q;

    // Frames may only start once cs has been seen high through a flushed synchronizer,
    // so a cs held low across reset cannot fake a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else if (settle_cnt != SETTLE_W'(SETTLE)) begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
        end else if (cs_level) begin
            armed <= 1'b1;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            fcnt       <= '0;
            rcnt       <= '0;
            addr_sh    <= '0;
            cur_ch     <= '0;
            dout_q     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            fcnt       <= fcnt_nxt;
            rcnt       <= rcnt_nxt;
            addr_sh    <= addr_nxt;
            cur_ch     <= cur_ch_nxt;
            dout_q     <= dout_nxt;
            frame_done <= done_nxt;
            frame_err  <= err_nxt;
        end
    end

    // Next-state and datapath update; cs_rise outranks sclk edges except on the 16th rise.
    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        fcnt_nxt   = fcnt;
        rcnt_nxt   = rcnt;
        addr_nxt   = addr_sh;
        cur_ch_nxt = cur_ch;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        rcnt_inc   = rcnt + CNT_W'(1);

        case (state)
            IDLE: begin
                if (cs_fall && armed) begin
                    shreg_nxt = frame_word(sample_c);
                    fcnt_nxt  = '0;
                    rcnt_nxt  = '0;
                    addr_nxt  = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    if (sclk_rise && rcnt_inc == CNT_W'(FRAME_LEN)) begin
                        cur_ch_nxt = addr_sh;
                        done_nxt   = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else begin
                    if (sclk_fall && fcnt < CNT_W'(FRAME_LEN - 1)) begin
                        shreg_nxt = shreg << 1;
                        fcnt_nxt  = fcnt + CNT_W'(1);
                    end
                    if (sclk_rise) begin
                        rcnt_nxt = rcnt_inc;
                        if (rcnt_inc >= CNT_W'(ADDR_FIRST) && rcnt_inc <= CNT_W'(ADDR_LAST)) begin
                            addr_nxt = {addr_sh[CH_W-2:0], din_level};
                        end
                        if (rcnt_inc == CNT_W'(FRAME_LEN)) begin
                            cur_ch_nxt = addr_sh;
                            done_nxt   = 1'b1;
                            state_nxt  = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        dout_nxt = (state_nxt == SHIFT) ? shreg_nxt[FRAME_LEN-1] : 1'b0;
    end

endmodule
